// File: rtl/bird_pkg.sv
// Shared encodings for the bird vertical-motion controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package bird_pkg;

  // Controller state, exported on the state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } state_t;

  // Motion mode select.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_PHYS   = 1'b1;

endpackage

// File: rtl/flap_latch.sv
// Flap latch: rising edge of the up button sets a pending flag, held until consumed.
// Latency: pending reflects a new edge combinationally in the same cycle; held flag is registered.
// Backpressure: none; a held button yields a single flap, further edges while pending merge.
module flap_latch (
  input  logic clk10,
  input  logic clr,
  input  logic up,
  input  logic consume,
  output logic pending
);

  logic r_up_q;
  logic r_pending;
  logic w_edge;

  assign w_edge  = up & ~r_up_q;
  // An edge arriving together with a consuming tick is used by that tick.
  assign pending = r_pending | w_edge;

  // Button history and pending flag; cleared on reset, flag dropped on consume.
  always_ff @(posedge clk10) begin
    if (!clr) begin
      r_up_q    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_up_q    <= up;
      r_pending <= pending & ~consume;
    end
  end

endmodule

// File: rtl/bird_motion.sv
// Bird vertical-motion controller: manual stepping or gravity/flap physics, clamped to the playfield.
// Latency: position/velocity/state/hit pulses are registered, visible one cycle after the tick.
// Backpressure: none; motion advances only on tick, game_end freezes the bird until clr.
module bird_motion
  import bird_pkg::*;
#(
  parameter int Y_WIDTH  = 10,
  parameter int V_WIDTH  = 6,
  parameter int Y_INIT   = 70,
  parameter int Y_MIN    = 15,
  parameter int Y_MAX    = 465,
  parameter int STEP     = 6,
  parameter int GRAVITY  = 1,
  parameter int FLAP_VEL = 6,
  parameter int V_MAX    = 8
) (
  input  logic                      clk10,
  input  logic                      clr,
  input  logic                      tick,
  input  logic                      mode,
  input  logic                      game_end,
  input  logic                      up,
  input  logic                      down,
  output logic [Y_WIDTH-1:0]        bird_y_pos,
  output logic signed [V_WIDTH-1:0] bird_vel,
  output logic [1:0]                state,
  output logic                      hit_ceiling,
  output logic                      hit_floor
);

  // Two guard bits so position +/- velocity or step never wraps.
  localparam int YE = Y_WIDTH + 2;

  localparam logic signed [YE-1:0]      C_YMIN   = YE'(Y_MIN);
  localparam logic signed [YE-1:0]      C_YMAX   = YE'(Y_MAX);
  localparam logic signed [YE-1:0]      C_STEP   = YE'(STEP);
  localparam logic [Y_WIDTH-1:0]        C_YINIT  = Y_WIDTH'(Y_INIT);
  localparam logic [Y_WIDTH-1:0]        C_YMIN_O = Y_WIDTH'(Y_MIN);
  localparam logic [Y_WIDTH-1:0]        C_YMAX_O = Y_WIDTH'(Y_MAX);
  localparam logic signed [V_WIDTH:0]   C_GRAV_E = (V_WIDTH+1)'(GRAVITY);
  localparam logic signed [V_WIDTH:0]   C_VMAX_E = (V_WIDTH+1)'(V_MAX);
  localparam logic signed [V_WIDTH-1:0] C_VMAX   = V_WIDTH'(V_MAX);
  localparam logic signed [V_WIDTH-1:0] C_FLAP   = V_WIDTH'(-FLAP_VEL);

  state_t                      r_state;
  logic [Y_WIDTH-1:0]          r_y;
  logic signed [V_WIDTH-1:0]   r_vel;
  logic                        r_hit_c;
  logic                        r_hit_f;

  state_t                      w_state_nxt;
  logic [Y_WIDTH-1:0]          w_y_nxt;
  logic signed [V_WIDTH-1:0]   w_vel_nxt;
  logic                        w_hit_c_nxt;
  logic                        w_hit_f_nxt;
  logic                        w_consume;
  logic                        w_pending;

  logic signed [V_WIDTH:0]     w_v_inc;
  logic signed [V_WIDTH-1:0]   w_v_phys;
  logic signed [YE-1:0]        w_y_ext;
  logic signed [YE-1:0]        w_vp_ext;
  logic signed [YE-1:0]        w_y_phys;
  logic signed [YE-1:0]        w_y_up;
  logic signed [YE-1:0]        w_y_dn;

  flap_latch u_flap_latch (
    .clk10   (clk10),
    .clr     (clr),
    .up      (up),
    .consume (w_consume),
    .pending (w_pending)
  );

  // Candidate moves: physics velocity/position and manual up/down steps.
  assign w_v_inc  = $signed({r_vel[V_WIDTH-1], r_vel}) + C_GRAV_E;
  assign w_v_phys = w_pending ? C_FLAP :
                    (w_v_inc > C_VMAX_E) ? C_VMAX : w_v_inc[V_WIDTH-1:0];
  assign w_y_ext  = $signed({2'b00, r_y});
  assign w_vp_ext = YE'(w_v_phys);
  assign w_y_phys = w_y_ext + w_vp_ext;
  assign w_y_up   = w_y_ext - C_STEP;
  assign w_y_dn   = w_y_ext + C_STEP;

  // Next-state, next-position and clamp decisions; game_end wins over tick.
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_vel_nxt   = r_vel;
    w_hit_c_nxt = 1'b0;
    w_hit_f_nxt = 1'b0;
    w_consume   = 1'b0;
    if (game_end) begin
      w_state_nxt = DEAD;
    end else if (tick) begin
      case (r_state)
        IDLE: begin
          // Physics start leaves the flap pending so it applies on the next tick.
          if (mode == MODE_PHYS) begin
            if (w_pending) w_state_nxt = FLY;
          end else if (up || down) begin
            w_state_nxt = FLY;
          end
        end
        FLY: begin
          if (mode == MODE_PHYS) begin
            w_consume = w_pending;
            if (w_y_phys < C_YMIN) begin
              w_y_nxt     = C_YMIN_O;
              w_vel_nxt   = '0;
              w_hit_c_nxt = 1'b1;
            end else if (w_y_phys > C_YMAX) begin
              w_y_nxt     = C_YMAX_O;
              w_vel_nxt   = '0;
              w_hit_f_nxt = 1'b1;
              w_state_nxt = DEAD;
            end else begin
              w_y_nxt   = w_y_phys[Y_WIDTH-1:0];
              w_vel_nxt = w_v_phys;
            end
          end else begin
            w_vel_nxt = '0;
            if (up && !down) begin
              if (w_y_up < C_YMIN) begin
                w_y_nxt     = C_YMIN_O;
                w_hit_c_nxt = 1'b1;
              end else begin
                w_y_nxt = w_y_up[Y_WIDTH-1:0];
              end
            end else if (down && !up) begin
              if (w_y_dn > C_YMAX) begin
                w_y_nxt     = C_YMAX_O;
                w_hit_f_nxt = 1'b1;
              end else begin
                w_y_nxt = w_y_dn[Y_WIDTH-1:0];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk10) begin
    if (!clr) begin
      r_state <= IDLE;
      r_y     <= C_YINIT;
      r_vel   <= '0;
      r_hit_c <= 1'b0;
      r_hit_f <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_vel   <= w_vel_nxt;
      r_hit_c <= w_hit_c_nxt;
      r_hit_f <= w_hit_f_nxt;
    end
  end

  assign bird_y_pos  = r_y;
  assign bird_vel    = r_vel;
  assign state       = r_state;
  assign hit_ceiling = r_hit_c;
  assign hit_floor   = r_hit_f;

endmodule
